mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the pipelined core's instruction-fetch port and its data (load/store) port.
- Serialises requests and allows one outstanding memory transaction at a time.
- Returns read data to the owning port only.
- Sits between the core and the memory. The core stalls fetch or memory stage on each port until that port's response arrives.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// Owner and state encodings are fixed 2-bit values so they can be probed on a bus.
package mem_port_arbiter_pkg;

    localparam int STARVE_MAX_DEF = 4;
    localparam int CNT_W          = 4;   // holds STARVE_MAX up to 15

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Fetch/data priority pick: data normally wins, fetch is forced through after
// STARVE_MAX back-to-back data grants that kept it waiting.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_i,
    output logic             grant_d,
    output logic [CNT_W-1:0] starve_cnt_next
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_MAX);

    logic starved;

    always_comb begin
        starved         = i_req && (starve_cnt == LIMIT);
        grant_d         = d_req && !starved;
        grant_i         = i_req && !grant_d;
        starve_cnt_next = starve_cnt;
        if (grant_i) begin
            starve_cnt_next = '0;
        end else if (grant_d && i_req && (starve_cnt != LIMIT)) begin
            starve_cnt_next = starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's fetch and data ports onto one single-ported memory,
// one outstanding transaction at a time, routing read data back to its owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ready,
    input  logic          m_rvalid,
    input  logic [DW-1:0] m_rdata,
    output logic          err
);

    arb_state_e       state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             err_q, err_d;
    logic             m_req_q, m_req_d;
    logic             m_we_q, m_we_d;
    logic [AW-1:0]    m_addr_q, m_addr_d;
    logic [DW-1:0]    m_wdata_q, m_wdata_d;

    logic             grant_i, grant_d;
    logic [CNT_W-1:0] pick_cnt_next;

    mem_arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .i_req          (i_req),
        .d_req          (d_req),
        .starve_cnt     (starve_cnt_q),
        .grant_i        (grant_i),
        .grant_d        (grant_d),
        .starve_cnt_next(pick_cnt_next)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        err_d        = err_q;
        m_req_d      = m_req_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        i_ready      = 1'b0;
        d_ready      = 1'b0;
        i_rvalid     = 1'b0;
        d_rvalid     = 1'b0;
        i_rdata      = m_rdata;
        d_rdata      = m_rdata;

        case (state_q)
            ST_IDLE: begin
                if (grant_i || grant_d) begin
                    starve_cnt_d = pick_cnt_next;
                    m_req_d      = 1'b1;
                    state_d      = ST_ISSUE;
                    if (grant_d) begin
                        d_ready   = 1'b1;
                        owner_d   = OWN_D;
                        m_we_d    = d_we;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                    end else begin
                        i_ready   = 1'b1;
                        owner_d   = OWN_I;
                        m_we_d    = 1'b0;
                        m_addr_d  = i_addr;
                        m_wdata_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                if (m_ready) begin
                    m_req_d = 1'b0;
                    // Stores get no memory response, so they complete on acceptance.
                    if (m_we_q) begin
                        d_rvalid = 1'b1;
                        owner_d  = OWN_NONE;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (m_rvalid) begin
                    i_rvalid = (owner_q == OWN_I);
                    d_rvalid = (owner_q == OWN_D);
                    owner_d  = OWN_NONE;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        // A response with nothing outstanding (e.g. from a transaction cut off by reset).
        if (m_rvalid && (state_q != ST_RESP)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            starve_cnt_q <= '0;
            err_q        <= 1'b0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            err_q        <= err_d;
            m_req_q      <= m_req_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: per-feature tasks with inline checks plus
// a response scoreboard fed at grant time and drained as rvalid pulses appear.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          clk;
    logic          reset_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ready;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_ready;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;
    logic          err;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            is_d;
        bit            is_store;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            tests_run    = 0;
    int            tests_failed = 0;
    bit            mem_auto;
    bit            pend;
    logic [AW-1:0] pend_addr;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return {a[15:0], 16'h5A5A} ^ 32'h1234_0000;
    endfunction

    function automatic exp_t make_exp(input bit is_d, input bit is_store, input logic [DW-1:0] data);
        exp_t e;
        e.is_d     = is_d;
        e.is_store = is_store;
        e.data     = data;
        return e;
    endfunction

    // Advance to the next negedge and play the memory: in auto mode it accepts
    // every request immediately and answers reads one cycle later.
    task automatic tick();
        @(negedge clk);
        m_rvalid  = pend;
        m_rdata   = pend ? mem_fn(pend_addr) : 32'h0BAD_F00D;
        m_ready   = mem_auto;
        pend      = mem_auto && m_req && !m_we;
        pend_addr = m_addr;
    endtask

    task automatic do_reset();
        tick();
        reset_n  = 1'b0;
        i_req    = 1'b0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        i_addr   = '0;
        d_addr   = '0;
        d_wdata  = '0;
        mem_auto = 1'b0;
        pend     = 1'b0;
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            #3;
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drain: %0d responses outstanding, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic scoreboard_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (i_rvalid || d_rvalid) begin
                tests_run++;
                if (i_rvalid && d_rvalid) begin
                    tests_failed++;
                    $display("FAIL sb_both: i_rvalid=1 d_rvalid=1, want one port only");
                end else if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected: i_rvalid=%b d_rvalid=%b, want no response", i_rvalid, d_rvalid);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_d !== d_rvalid) begin
                        tests_failed++;
                        $display("FAIL sb_port: got d_rvalid=%b, want port d=%b", d_rvalid, e.is_d);
                    end else if (!e.is_store && ((d_rvalid ? d_rdata : i_rdata) !== e.data)) begin
                        tests_failed++;
                        $display("FAIL sb_data: got %h, want %h", (d_rvalid ? d_rdata : i_rdata), e.data);
                    end else begin
                        $display("[TB] resp port=%s data=%h ok", e.is_d ? "d" : "i", e.data);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests_run++;
        if ({m_req, m_we, err, i_ready, d_ready, i_rvalid, d_rvalid} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b, want 0000000",
                     {m_req, m_we, err, i_ready, d_ready, i_rvalid, d_rvalid});
        end
        tests_run++;
        if ({m_addr, m_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_bus: m_addr=%h m_wdata=%h, want 0", m_addr, m_wdata);
        end
    endtask

    task automatic test_fetch_read();
        do_reset();
        mem_auto = 1'b1;
        tick();
        i_req  = 1'b1;
        i_addr = 32'h40;
        #1;
        tests_run++;
        if (i_ready !== 1'b1 || d_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL t1_ready: i_ready=%b d_ready=%b, want 1 0", i_ready, d_ready);
        end
        exp_q.push_back(make_exp(1'b0, 1'b0, 32'hDEADBEEF));
        tick();
        i_req = 1'b0;
        #1;
        tests_run++;
        if (m_req !== 1'b1 || m_addr !== 32'h40 || m_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL t1_mreq: m_req=%b m_addr=%h m_we=%b, want 1 00000040 0", m_req, m_addr, m_we);
        end
        tick();
        #1;
        tests_run++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'hDEADBEEF || d_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL t1_rvalid: i_rvalid=%b i_rdata=%h d_rvalid=%b, want 1 deadbeef 0",
                     i_rvalid, i_rdata, d_rvalid);
        end
        drain("t1");
    endtask

    task automatic test_store();
        do_reset();
        tick();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h84;
        d_wdata = 32'h25;
        #1;
        tests_run++;
        if (d_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL t2_ready: d_ready=%b, want 1", d_ready);
        end
        exp_q.push_back(make_exp(1'b1, 1'b1, '0));
        for (int c = 0; c < 3; c++) begin
            tick();
            d_req = 1'b0;
            #1;
            tests_run++;
            if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h84 || m_wdata !== 32'h25 || d_rvalid !== 1'b0) begin
                tests_failed++;
                $display("FAIL t2_hold%0d: req=%b we=%b addr=%h wdata=%h rv=%b, want 1 1 84 25 0",
                         c, m_req, m_we, m_addr, m_wdata, d_rvalid);
            end
        end
        tick();
        m_ready = 1'b1;
        #1;
        tests_run++;
        if (d_rvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL t2_done: d_rvalid=%b, want 1", d_rvalid);
        end
        mem_auto = 1'b1;
        tick();
        i_req  = 1'b1;
        i_addr = 32'h100;
        #1;
        tests_run++;
        if (m_req !== 1'b0 || i_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL t2_idle: m_req=%b i_ready=%b, want 0 1", m_req, i_ready);
        end
        exp_q.push_back(make_exp(1'b0, 1'b0, mem_fn(32'h100)));
        tick();
        i_req = 1'b0;
        drain("t2");
    endtask

    task automatic test_starvation();
        byte   grants[$];
        int    gcyc[$];
        string exp_s = "ddddiddddi";
        bit    adv_i = 1'b0;
        bit    adv_d = 1'b0;
        do_reset();
        mem_auto = 1'b1;
        i_addr   = 32'h1000;
        d_addr   = 32'h2000;
        d_we     = 1'b0;
        for (int c = 0; c < 60 && grants.size() < 10; c++) begin
            tick();
            i_req = 1'b1;
            d_req = 1'b1;
            if (adv_i) i_addr = i_addr + 32'd4;
            if (adv_d) d_addr = d_addr + 32'd4;
            adv_i = 1'b0;
            adv_d = 1'b0;
            #1;
            if (i_ready) begin
                grants.push_back("i");
                gcyc.push_back(c);
                exp_q.push_back(make_exp(1'b0, 1'b0, mem_fn(i_addr)));
                adv_i = 1'b1;
            end
            if (d_ready) begin
                grants.push_back("d");
                gcyc.push_back(c);
                exp_q.push_back(make_exp(1'b1, 1'b0, mem_fn(d_addr)));
                adv_d = 1'b1;
            end
        end
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        tests_run++;
        if (grants.size() != 10) begin
            tests_failed++;
            $display("FAIL t3_count: got %0d grants, want 10", grants.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                tests_run++;
                if (grants[k] !== exp_s[k]) begin
                    tests_failed++;
                    $display("FAIL t3_order%0d: got %c, want %c", k, grants[k], exp_s[k]);
                end else begin
                    $display("[TB] grant %0d = %c ok", k, grants[k]);
                end
            end
            for (int k = 1; k < 10; k++) begin
                tests_run++;
                if (gcyc[k] - gcyc[k-1] != 3) begin
                    tests_failed++;
                    $display("FAIL t3_spacing%0d: got %0d cycles, want 3", k, gcyc[k] - gcyc[k-1]);
                end
            end
        end
        drain("t3");
    endtask

    task automatic test_reset_in_resp();
        do_reset();
        tick();
        i_req  = 1'b1;
        i_addr = 32'h200;
        #1;
        tests_run++;
        if (i_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL t4_ready: i_ready=%b, want 1", i_ready);
        end
        tick();
        i_req   = 1'b0;
        m_ready = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        tests_run++;
        if (m_req !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL t4_after_rst: m_req=%b err=%b, want 0 0", m_req, err);
        end
        tick();
        tick();
        m_rvalid = 1'b1;
        m_rdata  = mem_fn(32'h200);
        #1;
        tests_run++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL t4_stale: i_rvalid=%b d_rvalid=%b, want 0 0", i_rvalid, d_rvalid);
        end
        mem_auto = 1'b1;
        tick();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h280;
        #1;
        tests_run++;
        if (err !== 1'b1 || d_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL t4_err_grant: err=%b d_ready=%b, want 1 1", err, d_ready);
        end
        exp_q.push_back(make_exp(1'b1, 1'b0, mem_fn(32'h280)));
        tick();
        d_req = 1'b0;
        drain("t4");
    endtask

    task automatic test_stray_rvalid();
        do_reset();
        tick();
        m_rvalid = 1'b1;
        m_rdata  = 32'h1111_2222;
        #1;
        tests_run++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL t5_stray: i_rv=%b d_rv=%b err=%b, want 0 0 0", i_rvalid, d_rvalid, err);
        end
        mem_auto = 1'b1;
        tick();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h500;
        d_wdata = 32'h77;
        #1;
        tests_run++;
        if (err !== 1'b1 || d_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL t5_err_set: err=%b d_ready=%b, want 1 1", err, d_ready);
        end
        exp_q.push_back(make_exp(1'b1, 1'b1, '0));
        tick();
        d_req = 1'b0;
        drain("t5");
        #1;
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL t5_sticky: err=%b, want 1", err);
        end
        do_reset();
        #1;
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL t5_clear: err=%b, want 0", err);
        end
    endtask

    task automatic test_drop_req();
        do_reset();
        tick();
        i_req  = 1'b1;
        i_addr = 32'h300;
        #1;
        tests_run++;
        if (i_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL t6_ready: i_ready=%b, want 1", i_ready);
        end
        exp_q.push_back(make_exp(1'b0, 1'b0, mem_fn(32'h300)));
        tick();
        i_req  = 1'b0;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h400;
        #1;
        tests_run++;
        if (d_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL t6_no_dgrant: d_ready=%b, want 0", d_ready);
        end
        tick();
        d_req   = 1'b0;
        m_ready = 1'b1;
        #1;
        tests_run++;
        if (m_req !== 1'b1 || m_addr !== 32'h300) begin
            tests_failed++;
            $display("FAIL t6_maddr: m_req=%b m_addr=%h, want 1 00000300", m_req, m_addr);
        end
        tick();
        m_rvalid = 1'b1;
        m_rdata  = mem_fn(32'h300);
        #1;
        tests_run++;
        if (i_rvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL t6_irv: i_rvalid=%b, want 1", i_rvalid);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            tests_run++;
            if (m_req !== 1'b0 || d_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL t6_quiet%0d: m_req=%b d_ready=%b, want 0 0", c, m_req, d_ready);
            end
        end
        drain("t6");
    endtask

    initial begin
        reset_n  = 1'b0;
        i_req    = 1'b0;
        i_addr   = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        mem_auto = 1'b0;
        pend     = 1'b0;
        pend_addr = '0;
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_fetch_read();
        test_store();
        test_starvation();
        test_reset_in_resp();
        test_stray_rvalid();
        test_drop_req();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at 200000, want finished");
        $fatal(1, "timeout");
    end

endmodule
